// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter sharing one multi-precision adder/subtractor between two requesters.
// Define MPADDER_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module mpadder_arbiter #(
   parameter int WIDTH = 1027
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req0,
   input  logic             sub0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             done0,
   input  logic             req1,
   input  logic             sub1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             done1,
   output logic [WIDTH:0]   result,
   output logic             busy,
   output logic             grant,
   output logic             add_start,
   output logic             add_subtract,
   output logic [WIDTH-1:0] add_in_a,
   output logic [WIDTH-1:0] add_in_b,
   input  logic [WIDTH:0]   add_result,
   input  logic             add_done
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t state, state_next;
   logic   take;
   logic   winner;
   logic   capture;
   logic   lp;

   always_comb begin
      state_next = state;
      take       = 1'b0;
      winner     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               take       = 1'b1;
               state_next = START;
               if (req0 && req1) begin
`ifdef MPADDER_ARB_FIXED_PRIO_EN
                  winner = 1'b0;
`else
                  winner = ~lp;
`endif
               end else begin
                  winner = req1;
               end
            end
         end
         START: state_next = WAIT;
         // add_done is only meaningful while an operation is outstanding
         WAIT: begin
            if (add_done) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         done0        <= 1'b0;
         done1        <= 1'b0;
         add_start    <= 1'b0;
         add_subtract <= 1'b0;
         busy         <= 1'b0;
         result       <= '0;
         add_in_a     <= '0;
         add_in_b     <= '0;
         grant        <= 1'b0;
         lp           <= 1'b1;
      end else begin
         state     <= state_next;
         add_start <= (state_next == START);
         busy      <= (state_next != IDLE);
         done0     <= (state_next == RESP) && !grant;
         done1     <= (state_next == RESP) && grant;
         if (take) begin
            grant        <= winner;
            lp           <= winner;
            add_subtract <= winner ? sub1 : sub0;
            add_in_a     <= winner ? a1 : a0;
            add_in_b     <= winner ? b1 : b0;
         end
         if (capture) begin
            result <= add_result;
         end
      end
   end

endmodule

// File: doc/mpadder_arbiter.md
Name: mpadder_arbiter

Overview:
Shares one multi-precision adder/subtractor (mpadder) between two requesters, e.g. the Montgomery multiplier core and the final-reduction stage.
- Arbitrates requests round-robin.
- Latches the winner's operands and op select, then issues a one-cycle start to the adder.
- Waits for the adder's done, registers the (WIDTH+1)-bit result and returns a one-cycle done pulse to the winning requester.
- Sits between the requesters and mpadder; the adder's own ports are driven only by this block.

Parameters:
- WIDTH, 1027, operand width in bits; the result is WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req0  input  1  requester 0 request; held high with stable operands until done0
- sub0  input  1  requester 0: 1 = a0-b0, 0 = a0+b0
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- done0  output  1  one-cycle pulse; result valid for requester 0
- req1  input  1  requester 1 request
- sub1  input  1  requester 1 op select
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- done1  output  1  one-cycle pulse; result valid for requester 1
- result  output  WIDTH+1  registered adder result; holds until the next completion
- busy  output  1  high in every state except IDLE
- grant  output  1  index of the current or most recent owner
- add_start  output  1  one-cycle start to mpadder
- add_subtract  output  1  op select to mpadder
- add_in_a  output  WIDTH  operand A to mpadder
- add_in_b  output  WIDTH  operand B to mpadder
- add_result  input  WIDTH+1  mpadder result
- add_done  input  1  mpadder completion pulse

Behaviour:
- Reset (async, resetn low): state=IDLE. done0, done1, add_start, add_subtract, busy = 0. result, add_in_a, add_in_b = 0. grant = 0. last-served pointer lp = 1, so requester 0 wins the first tie.
- Interface: all outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Only reqX high: winner = X.
  - Both high: winner = !lp.
  - On the cycle a request is taken: latch aX/bX/subX into add_in_a/add_in_b/add_subtract, set grant = winner and lp = winner, go to START.
- START:
  - add_start=1 for exactly this one cycle; go to WAIT.
  - add_in_a/add_in_b/add_subtract stay stable from START until the next grant.
- WAIT:
  - add_start=0.
  - add_done is sampled only in this state; add_done seen in any other state is ignored.
  - On add_done: result <= add_result, go to RESP.
- RESP:
  - done[grant]=1 for exactly one cycle; the other done stays 0; go to IDLE.
  - Requests are not sampled in RESP.
- Requester contract:
  - Deassert req on the cycle after done is seen, or keep it high to request a new operation with new operands.
  - A request still high when IDLE is re-entered is treated as a new request.
- Latency: from a request sampled in IDLE at edge N, add_start is high in cycle N+1; done is high one cycle after the add_done cycle.
- Back-to-back: the minimum gap between consecutive add_start pulses is 4 cycles plus the adder latency.
- Fairness:
  - Under continuous requests from both sides, grants alternate 0,1,0,1...
  - A sole requester may win repeatedly.
- Width: result is a pass-through of the adder's WIDTH+1 bits; no truncation or sign handling in this block.
- Reset mid-operation:
  - Immediate return to reset values.
  - Any pending result is dropped and no done is emitted.
  - The adder shares resetn and is assumed reset with this block.
- Requests that drop before being granted are simply not served; no error is raised.

Optional Feature:
MPADDER_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Requester 0 always wins when both request; lp is unused (may still be present).
- Not defined: round-robin as described above.
- All other timing is identical in both configurations.

Test Plan:
1. Reset then req0, sub0=0, a0=1000, b0=2000 -> one add_start pulse with add_in_a=1000, add_in_b=2000, add_subtract=0; done0 pulses once with result=3000; done1 stays 0.
2. req1, sub1=1, a1=3000, b1=1500 -> add_subtract=1, grant=1; done1 pulses with result=1500; busy is low again the cycle after done1.
3. req0 and req1 raised in the same cycle and kept high with new operands after each done -> grant sequence 0,1,0,1; each done carries its own operand sum. With MPADDER_ARB_FIXED_PRIO_EN defined -> 0,0,0,... while req0 stays high.
4. Full-width operands: a0 = all ones (WIDTH bits), b0 = 1, add -> result = 1 followed by WIDTH zeros, i.e. bit WIDTH set; subtract with a0=0, b0=0 -> result = 0.
5. resetn asserted during WAIT, with add_done arriving afterwards -> all outputs at reset values; no done pulse; the next req0 is served normally with grant=0.
6. Spurious add_done in IDLE, and req held high through RESP -> no result update and no extra done; the held request is re-granted only after IDLE is re-entered.
